// File: rtl/user_wb_arbiter.sv
// Two-requester Wishbone arbiter sharing one target port.
// Requesters alternate on ties. A stalled target is cut off after TIMEOUT
// cycles, and the owner then receives a 32'hDEADBEEF completion.
module user_wb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic        timeout_irq_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               s_cyc_d;
    logic               s_we_d;
    logic [SEL_W-1:0]   s_sel_d;
    logic [DATA_W-1:0]  s_adr_d;
    logic [DATA_W-1:0]  s_dat_d;
    logic               m0_ack_d, m1_ack_d;
    logic [DATA_W-1:0]  m0_dat_d, m1_dat_d;
    logic               irq_d;

    logic               req0, req1;
    logic               owner_req;
    logic               grant;
    logic               complete;
    logic [DATA_W-1:0]  rsp_dat;

    assign req0      = m0_cyc_i & m0_stb_i;
    assign req1      = m1_cyc_i & m1_stb_i;
    assign owner_req = owner_q ? req1 : req0;

    // Strobe mirrors cycle on the shared target port.
    assign s_stb_o = s_cyc_o;

    // Grant choice: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_owner_q;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        s_cyc_d      = 1'b0;
        s_we_d       = s_we_o;
        s_sel_d      = s_sel_o;
        s_adr_d      = s_adr_o;
        s_dat_d      = s_dat_o;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_dat_d     = m0_dat_o;
        m1_dat_d     = m1_dat_o;
        irq_d        = 1'b0;
        complete     = 1'b0;
        rsp_dat      = s_dat_i;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d      = ST_XFER;
                    owner_d      = grant;
                    last_owner_d = grant;
                    cnt_d        = '0;
                    s_cyc_d      = 1'b1;
                    s_we_d       = grant ? m1_we_i  : m0_we_i;
                    s_sel_d      = grant ? m1_sel_i : m0_sel_i;
                    s_adr_d      = grant ? m1_adr_i : m0_adr_i;
                    s_dat_d      = grant ? m1_dat_i : m0_dat_i;
                end
            end

            ST_XFER: begin
                if (!owner_req) begin
                    // Owner withdrew: drop the target cycle silently.
                    state_d = ST_IDLE;
                end else if (s_ack_i) begin
                    state_d  = ST_DONE;
                    complete = 1'b1;
                    rsp_dat  = s_dat_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    complete = 1'b1;
                    rsp_dat  = TIMEOUT_DATA;
                    irq_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    s_cyc_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Route the completion to the owner only.
        if (complete) begin
            if (owner_q) begin
                m1_ack_d = 1'b1;
                m1_dat_d = rsp_dat;
            end else begin
                m0_ack_d = 1'b1;
                m0_dat_d = rsp_dat;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            cnt_q         <= '0;
            s_cyc_o       <= 1'b0;
            s_we_o        <= 1'b0;
            s_sel_o       <= '0;
            s_adr_o       <= '0;
            s_dat_o       <= '0;
            m0_ack_o      <= 1'b0;
            m1_ack_o      <= 1'b0;
            m0_dat_o      <= '0;
            m1_dat_o      <= '0;
            timeout_irq_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            cnt_q         <= cnt_d;
            s_cyc_o       <= s_cyc_d;
            s_we_o        <= s_we_d;
            s_sel_o       <= s_sel_d;
            s_adr_o       <= s_adr_d;
            s_dat_o       <= s_dat_d;
            m0_ack_o      <= m0_ack_d;
            m1_ack_o      <= m1_ack_d;
            m0_dat_o      <= m0_dat_d;
            m1_dat_o      <= m1_dat_d;
            timeout_irq_o <= irq_d;
        end
    end

endmodule

// File: tb/tb_user_wb_arbiter.sv
// Directed bench for user_wb_arbiter with a transaction-level reference model.
module tb_user_wb_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [3:0]  m0_sel = 0;
    logic [31:0] m0_adr = 0, m0_wdat = 0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [3:0]  m1_sel = 0;
    logic [31:0] m1_adr = 0, m1_wdat = 0;
    logic        s_ack = 0;
    logic [31:0] s_rdat = 0;

    logic        m0_ack_o, m1_ack_o, s_cyc_o, s_stb_o, s_we_o, timeout_irq_o;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    user_wb_arbiter #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .timeout_irq_o(timeout_irq_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: who holds the target and for how many cycles.
    int          phase = 0;      // 0 free, 1 transfer in flight, 2 completion cycle
    int          own = 0, last = 1, age = 0;
    bit          model_ok = 0;
    logic        e_cyc = 0, e_we = 0, e_irq = 0;
    logic [3:0]  e_sel = 0;
    logic [31:0] e_adr = 0, e_wd = 0;
    logic        e_ack [2];
    logic [31:0] e_dat [2];

    always @(posedge clk) begin
        bit r0, r1, ro;
        r0 = m0_cyc & m0_stb;
        r1 = m1_cyc & m1_stb;
        model_ok = 1;
        e_ack[0] = 0; e_ack[1] = 0; e_irq = 0;
        if (rst) begin
            phase = 0; own = 0; last = 1; age = 0;
            e_cyc = 0; e_we = 0; e_sel = 0; e_adr = 0; e_wd = 0;
            e_dat[0] = 0; e_dat[1] = 0;
        end else if (phase == 1) begin
            ro = (own == 1) ? r1 : r0;
            e_cyc = 0;
            if (!ro) begin
                phase = 0;
            end else if (s_ack) begin
                phase = 2; e_ack[own] = 1; e_dat[own] = s_rdat;
            end else if (age + 1 == TO) begin
                phase = 2; e_ack[own] = 1; e_dat[own] = 32'hDEADBEEF; e_irq = 1;
            end else begin
                age++; e_cyc = 1;
            end
        end else if (phase == 2) begin
            phase = 0;
        end else if (r0 || r1) begin
            own   = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
            last  = own;
            age   = 0;
            phase = 1;
            e_cyc = 1;
            e_we  = own ? m1_we   : m0_we;
            e_sel = own ? m1_sel  : m0_sel;
            e_adr = own ? m1_adr  : m0_adr;
            e_wd  = own ? m1_wdat : m0_wdat;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("s_cyc",  32'(s_cyc_o),  32'(e_cyc));
            chk("s_stb",  32'(s_stb_o),  32'(e_cyc));
            chk("s_we",   32'(s_we_o),   32'(e_we));
            chk("s_sel",  32'(s_sel_o),  32'(e_sel));
            chk("s_adr",  s_adr_o,       e_adr);
            chk("s_dat",  s_dat_o,       e_wd);
            chk("m0_ack", 32'(m0_ack_o), 32'(e_ack[0]));
            chk("m1_ack", 32'(m1_ack_o), 32'(e_ack[1]));
            chk("m0_dat", m0_dat_o,      e_dat[0]);
            chk("m1_dat", m1_dat_o,      e_dat[1]);
            chk("irq",    32'(timeout_irq_o), 32'(e_irq));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic c, input logic s, input logic w,
                         input logic [3:0] sl, input logic [31:0] a, input logic [31:0] d);
        if (i == 0) begin
            m0_cyc = c; m0_stb = s; m0_we = w; m0_sel = sl; m0_adr = a; m0_wdat = d;
        end else begin
            m1_cyc = c; m1_stb = s; m1_we = w; m1_sel = sl; m1_adr = a; m1_wdat = d;
        end
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    initial begin
        // Reset values
        step(); step();
        chk("lit_rst_cyc", 32'(s_cyc_o), 32'd0);
        chk("lit_rst_adr", s_adr_o, 32'd0);
        chk("lit_rst_dat", m0_dat_o, 32'd0);
        rst = 0;

        // Single read with minimum latency
        drive(0, 1, 1, 0, 4'hF, 32'h3000_0004, 32'h0);
        step();
        chk("lit_rd_cyc", 32'(s_cyc_o), 32'd1);
        chk("lit_rd_adr", s_adr_o, 32'h3000_0004);
        s_ack = 1; s_rdat = 32'h1234_5678;
        step();
        chk("lit_rd_ack", 32'(m0_ack_o), 32'd1);
        chk("lit_rd_dat", m0_dat_o, 32'h1234_5678);
        s_ack = 0;
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        step();
        chk("lit_rd_ack_low", 32'(m0_ack_o), 32'd0);

        // Ties after reset: m0 first, then alternate
        do_reset();
        drive(0, 1, 1, 0, 4'hF, 32'h3000_0100, 32'h0);
        drive(1, 1, 1, 0, 4'hF, 32'h3000_0200, 32'h0);
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 8 && !s_cyc_o; w++) step();
            chk("tie_grant_seen", 32'(s_cyc_o), 32'd1);
            chk("lit_tie_adr", s_adr_o, (k % 2 == 1) ? 32'h3000_0200 : 32'h3000_0100);
            s_ack = 1; s_rdat = 32'(k + 16);
            step();
            s_ack = 0;
            chk("lit_tie_ack0", 32'(m0_ack_o), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("lit_tie_ack1", 32'(m1_ack_o), (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        step();

        // Timeout after TO silent transfer cycles
        do_reset();
        drive(0, 1, 1, 0, 4'hF, 32'h3000_0008, 32'h0);
        for (int n = 1; n <= 4; n++) begin
            step();
            chk("lit_to_busy", 32'(s_cyc_o), 32'd1);
            chk("lit_to_noack", 32'(m0_ack_o), 32'd0);
        end
        step();
        chk("lit_to_ack", 32'(m0_ack_o), 32'd1);
        chk("lit_to_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("lit_to_irq", 32'(timeout_irq_o), 32'd1);
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        step();
        chk("lit_to_irq_pulse", 32'(timeout_irq_o), 32'd0);

        // Ack landing on the timeout cycle completes normally
        drive(1, 1, 1, 0, 4'hF, 32'h3000_000C, 32'h0);
        for (int n = 1; n <= 4; n++) begin
            step();
            if (n == 4) begin s_ack = 1; s_rdat = 32'hA5A5_A5A5; end
        end
        step();
        s_ack = 0;
        chk("lit_race_ack", 32'(m1_ack_o), 32'd1);
        chk("lit_race_dat", m1_dat_o, 32'hA5A5_A5A5);
        chk("lit_race_irq", 32'(timeout_irq_o), 32'd0);
        drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        step();

        // m1 write with partial selects, then abort
        drive(1, 1, 1, 1, 4'b0011, 32'h3000_0010, 32'hCAFE_0001);
        step();
        chk("lit_wr_sel", 32'(s_sel_o), 32'h3);
        chk("lit_wr_we", 32'(s_we_o), 32'd1);
        chk("lit_wr_dat", s_dat_o, 32'hCAFE_0001);
        m1_stb = 0;
        step();
        chk("lit_ab_cyc", 32'(s_cyc_o), 32'd0);
        chk("lit_ab_ack", 32'(m1_ack_o), 32'd0);
        s_ack = 1; s_rdat = 32'h0BAD_0BAD;
        step();
        s_ack = 0;
        chk("lit_ab_ack2", 32'(m1_ack_o), 32'd0);
        chk("lit_ab_dat", m1_dat_o, 32'hA5A5_A5A5);
        m1_cyc = 0;
        step();

        // Reset in the middle of a transfer
        drive(0, 1, 1, 1, 4'hF, 32'h3000_0020, 32'h5555_AAAA);
        step();
        chk("lit_mr_busy", 32'(s_cyc_o), 32'd1);
        rst = 1; s_ack = 1; s_rdat = 32'h7777_7777;
        step();
        s_ack = 0;
        chk("lit_mr_cyc", 32'(s_cyc_o), 32'd0);
        chk("lit_mr_ack", 32'(m0_ack_o), 32'd0);
        chk("lit_mr_adr", s_adr_o, 32'd0);
        chk("lit_mr_sdat", s_dat_o, 32'd0);
        chk("lit_mr_mdat", m0_dat_o, 32'd0);
        rst = 0;
        step();
        chk("lit_mr_regrant", 32'(s_cyc_o), 32'd1);
        s_ack = 1; s_rdat = 32'h0102_0304;
        step();
        s_ack = 0;
        chk("lit_mr_dat", m0_dat_o, 32'h0102_0304);
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
